// File: rtl/arb_rr_pkt.sv
// Packet-granular round-robin arbiter: locks the grant for a whole packet and
// rotates priority past the winner on release, with an optional beat watchdog.
module arb_rr_pkt #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5,
  localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] req_last,
  output logic [WIDTH-1:0] req_rdy,
  output logic             out_vld,
  output logic             out_last,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             busy,
  output logic             trunc
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic WD_EN = (MAX_BEATS > 0) ? 1'b1 : 1'b0;

  state_t             state_r;
  logic [WIDTH-1:0]   ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] dbl_req_s;
  logic [2*WIDTH-1:0] dbl_win_s;
  logic [WIDTH-1:0]   win_s;
  logic               acc_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               wd_hit_s;

  function automatic logic [IW-1:0] oh2idx(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) idx = idx | IW'(i);
      else       idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] oh);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) r[(i + 1) % WIDTH] = oh[i];
    return r;
  endfunction

  // Winner select: the borrow of (req - ptr) over a doubled vector clears every
  // request below the pointer, so the lowest surviving bit wraps naturally.
  always_comb begin
    dbl_req_s = {req, req};
    dbl_win_s = dbl_req_s & ~(dbl_req_s - {{WIDTH{1'b0}}, ptr_r});
    win_s     = dbl_win_s[WIDTH-1:0] | dbl_win_s[2*WIDTH-1:WIDTH];
  end

  // Channel steering and beat-accept / watchdog detection from the held grant.
  always_comb begin
    req_rdy   = grant & {WIDTH{out_rdy}};
    out_vld   = |(req & grant);
    out_last  = |(req_last & req & grant);
    acc_s     = out_vld & out_rdy;
    cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    wd_hit_s  = WD_EN & (cnt_inc_s == CNT_W'(MAX_BEATS));
  end

  // Arbitration FSM with registered grant, index, busy and trunc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      grant     <= {WIDTH{1'b0}};
      grant_idx <= {IW{1'b0}};
      busy      <= 1'b0;
      trunc     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      ptr_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      case (state_r)
        IDLE: begin
          trunc <= 1'b0;
          if (|req) begin
            state_r   <= LOCK;
            grant     <= win_s;
            grant_idx <= oh2idx(win_s);
            busy      <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
          end
        end
        LOCK: begin
          // A last beat takes precedence over the watchdog, so trunc only
          // fires when the release was forced.
          if (acc_s && (out_last || wd_hit_s)) begin
            state_r   <= IDLE;
            grant     <= {WIDTH{1'b0}};
            grant_idx <= {IW{1'b0}};
            busy      <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            ptr_r     <= rotl1(grant);
            trunc     <= ~out_last;
          end else begin
            trunc <= 1'b0;
            if (acc_s) cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          grant     <= {WIDTH{1'b0}};
          grant_idx <= {IW{1'b0}};
          busy      <= 1'b0;
          trunc     <= 1'b0;
          cnt_r     <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_pkt.sv
// Bench for arb_rr_pkt: directed scenarios plus random traffic, all checked
// against a requester-index reference model of packet round-robin arbitration.
module tb_arb_rr_pkt;

  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] req;
  logic [W-1:0] req_last;
  logic [W-1:0] req_rdy;
  logic         out_vld;
  logic         out_last;
  logic         out_rdy;
  logic [W-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         trunc;

  int n_chk;
  int n_fail;

  // model: who owns the channel, whose turn it is, beats so far
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_trunc;

  arb_rr_pkt #(.WIDTH(W), .MAX_BEATS(MAXB), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_last(out_last), .out_rdy(out_rdy), .grant(grant),
    .grant_idx(grant_idx), .busy(busy), .trunc(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cnt    = 0;
    m_trunc  = 1'b0;
  endtask

  task automatic release_owner(input bit forced);
    m_locked = 1'b0;
    m_ptr    = (m_owner + 1) % W;
    m_trunc  = forced;
  endtask

  // One clock: apply inputs, check the cycle's outputs, advance the model.
  task automatic step(input logic r, input logic [W-1:0] q, input logic [W-1:0] l, input logic rd);
    logic [31:0] e_grant;
    bit found;
    @(negedge clk);
    rst = r; req = q; req_last = l; out_rdy = rd;
    #1;
    e_grant = m_locked ? (32'd1 << m_owner) : 32'd0;
    chk("grant", {28'd0, grant}, e_grant);
    chk("grant_idx", {30'd0, grant_idx}, m_locked ? 32'(m_owner) : 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, m_locked});
    chk("trunc", {31'd0, trunc}, {31'd0, m_trunc});
    chk("req_rdy", {28'd0, req_rdy}, rd ? e_grant : 32'd0);
    chk("out_vld", {31'd0, out_vld}, {31'd0, m_locked && q[m_owner]});
    chk("out_last", {31'd0, out_last}, {31'd0, m_locked && q[m_owner] && l[m_owner]});
    if (r) begin
      model_reset();
    end else if (!m_locked) begin
      m_trunc = 1'b0;
      found = 1'b0;
      for (int k = 0; k < W; k++) begin
        if (!found && q[(m_ptr + k) % W]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % W;
        end
      end
      if (found) begin
        m_locked = 1'b1;
        m_cnt    = 0;
      end
    end else begin
      m_trunc = 1'b0;
      if (q[m_owner] && rd) begin
        m_cnt++;
        if (l[m_owner]) release_owner(1'b0);
        else if (MAXB > 0 && m_cnt == MAXB) release_owner(1'b1);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; req = '0; req_last = '0; out_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state, then single-beat packets from requesters 1 and 2
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_g0", {28'd0, grant}, 32'h0);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_g1", {28'd0, grant}, 32'h2);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_bub", {28'd0, grant}, 32'h0);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_g2", {28'd0, grant}, 32'h4);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_bub2", {28'd0, grant}, 32'h0);
    step(1'b0, 4'b0110, 4'b0110, 1'b1); chk("t1_g3", {28'd0, grant}, 32'h2);

    // pointer wrap after requester 3
    step(1'b0, 4'b1000, 4'b1000, 1'b1);
    step(1'b0, 4'b1000, 4'b1000, 1'b1); chk("wrap_g3", {28'd0, grant}, 32'h8);
    step(1'b0, 4'b1001, 4'b1001, 1'b1);
    step(1'b0, 4'b1001, 4'b1001, 1'b1); chk("wrap_g0", {28'd0, grant}, 32'h1);

    // 3-beat lock for requester 1 with out_rdy 1,0,1,1
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b1); chk("lock_rdy1", {28'd0, req_rdy}, 32'h2);
    step(1'b0, 4'b1111, 4'b0000, 1'b0); chk("lock_rdy0", {28'd0, req_rdy}, 32'h0);
    step(1'b0, 4'b1111, 4'b0000, 1'b1); chk("lock_g", {28'd0, grant}, 32'h2);
    step(1'b0, 4'b1111, 4'b0010, 1'b1); chk("lock_last", {31'd0, out_last}, 32'h1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1); chk("lock_rel", {28'd0, grant}, 32'h0);

    // watchdog: requester 2 streams without last
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b1011, 1'b1);
    chk("wd_trunc", {31'd0, trunc}, 32'h1);
    chk("wd_gap", {28'd0, grant}, 32'h0);
    step(1'b0, 4'b1111, 4'b1011, 1'b1); chk("wd_next", {28'd0, grant}, 32'h8);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, 4'b1011, 1'b1);

    // boundary: last on the MAX_BEATS-th beat is a normal release
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0100, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("bnd_trunc", {31'd0, trunc}, 32'h0);
    chk("bnd_rel", {28'd0, grant}, 32'h0);

    // reset in the middle of a packet
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    chk("mrst_g", {28'd0, grant}, 32'h0);
    chk("mrst_busy", {31'd0, busy}, 32'h0);
    step(1'b0, 4'b1111, 4'b0000, 1'b1); chk("mrst_g0", {28'd0, grant}, 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
           4'($urandom), 4'($urandom & $urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_rr_pkt.md
Name: arb_rr_pkt

Overview:
- Sequential round-robin arbiter that shares one downstream valid/ready channel between WIDTH requesters, at packet granularity.
- Grant is locked to the winner from its first beat until it transfers a beat with last set, then priority rotates past the winner.
- Optional beat-count watchdog force-releases a requester whose packet exceeds MAX_BEATS.
- Sits in front of shared datapaths. The per-cycle winner selection uses the rotating-priority (double-vector subtract) scheme already in use in the arbiter library.

Parameters:
- WIDTH, 4, number of requesters (>=1).
- MAX_BEATS, 16, max beats per packet before forced release; 0 disables the watchdog.
- CNT_W, 5, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  WIDTH  per-requester beat valid.
- req_last  input  WIDTH  per-requester last-beat flag, qualified by req.
- req_rdy  output  WIDTH  per-requester ready; equals grant & {WIDTH{out_rdy}}.
- out_vld  output  1  downstream valid; equals |(req & grant).
- out_last  output  1  downstream last; equals |(req_last & grant) while out_vld.
- out_rdy  input  1  downstream ready.
- grant  output  WIDTH  registered one-hot grant; all-zero when idle.
- grant_idx  output  max(1,$clog2(WIDTH))  binary index of grant; 0 when idle.
- busy  output  1  high while in state LOCK.
- trunc  output  1  one-cycle pulse on watchdog forced release.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, grant=0, grant_idx=0, busy=0, trunc=0, beat counter=0.
  - Priority pointer (one-hot) = bit 0.
  - Reset mid-packet abandons the packet with no further transfers.
- Winner function:
  - First set bit of req at or above the pointer position, scanning upward and wrapping from WIDTH-1 to 0.
  - Result is one-hot or zero.
- IDLE:
  - If |req: register winner into grant, go to LOCK, beat counter=0.
  - Latency is 1 cycle from req rising to grant/out_vld.
  - Else remain in IDLE.
  - out_vld=0 and req_rdy=0 in IDLE.
- LOCK:
  - grant is held constant; requests from other requesters are ignored.
  - Beat accepted when out_vld & out_rdy.
  - Each accepted beat increments the beat counter.
  - Requester deasserting req while granted causes no transfer; grant is held and no timeout applies.
- Release on accepted beat with out_last=1:
  - Next cycle: state=IDLE, grant=0.
  - Pointer = winner rotated left by 1 (bit WIDTH-1 wraps to bit 0).
  - Exactly one idle bubble cycle separates packets.
- Forced release (MAX_BEATS>0), when an accepted non-last beat brings the counter to MAX_BEATS:
  - Release exactly as for a last beat.
  - trunc=1 for the following cycle.
  - The requester's remaining beats are re-arbitrated as a new packet.
- Simultaneous last and watchdog on the same beat: treated as a normal last; trunc stays 0.
- WIDTH=1: grant=req-registered, pointer constant, lock/release rules unchanged.
- out_rdy may toggle freely; no combinational path from out_rdy to grant.

Test Plan:
- Reset, then req=4'b0110 with single-beat packets and out_rdy=1:
  - grant sequence is 0010, 0 (bubble), 0100, 0, 0010.
  - Pointer after the first packet = 0100.
- Pointer wrap:
  - Requester 3 finishes a packet, then req=4'b1001.
  - Next grant=0001 (wrap to requester 0), not 1000.
- Lock:
  - Requester 1 sends a 3-beat packet with out_rdy pattern 1,0,1,1.
  - req=1111 throughout, grant stays 0010 for 4 cycles.
  - req_rdy=0010 only when out_rdy=1; release after the 3rd accepted beat.
- Watchdog with MAX_BEATS=4:
  - Requester 2 streams 6 beats with last only on beat 6.
  - trunc pulses one cycle after beat 4; grant drops to 0 for one cycle.
  - Requester 2 is regranted only after other pending requesters are served.
- Boundary: last on beat 4 with MAX_BEATS=4 → normal release, trunc=0.
- Reset mid-LOCK at beat 2 of 5:
  - Next cycle grant=0, busy=0, pointer=0001.
  - With req=1111 the next grant=0001.
